// File: rtl/axis_width_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide beat.
// Define AXIS_UPSIZE_STATS_EN to add packet/beat counters and stats_clr.
module axis_width_upsizer #(
   parameter int DW    = 8,
   parameter int RATIO = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [DW-1:0]       s_tdata,
   input  logic                s_tvalid,
   output logic                s_tready,
   input  logic                s_tlast,
   output logic [DW*RATIO-1:0] m_tdata,
   output logic [RATIO-1:0]    m_tkeep,
   output logic                m_tvalid,
   input  logic                m_tready,
   output logic                m_tlast
`ifdef AXIS_UPSIZE_STATS_EN
   ,
   input  logic                stats_clr,
   output logic [15:0]         pkt_cnt,
   output logic [15:0]         beat_cnt
`endif
);

   localparam int CW = $clog2(RATIO);
   localparam int WW = DW * RATIO;

   logic [WW-1:0]    acc;
   logic [WW-1:0]    wide;
   logic [RATIO-1:0] keep_acc;
   logic [RATIO-1:0] keep_new;
   logic [CW-1:0]    idx;
   logic             hs;
   logic             last_lane;
   logic             complete;

   assign s_tready  = rstn && (!m_tvalid || m_tready);
   assign hs        = s_tvalid && s_tready;
   assign last_lane = (idx == CW'(RATIO - 1));
   assign complete  = hs && (last_lane || s_tlast);

   // lanes above idx are always zero in acc, so no extra masking is needed
   always_comb begin
      wide                 = acc;
      wide[idx*DW +: DW]   = s_tdata;
      keep_new             = keep_acc | (RATIO'(1) << idx);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         m_tdata  <= '0;
         m_tkeep  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         acc      <= '0;
         keep_acc <= '0;
         idx      <= '0;
      end else begin
         if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
         end
         if (complete) begin
            m_tdata  <= wide;
            m_tkeep  <= keep_new;
            m_tlast  <= s_tlast;
            m_tvalid <= 1'b1;
            acc      <= '0;
            keep_acc <= '0;
            idx      <= '0;
         end else if (hs) begin
            acc      <= wide;
            keep_acc <= keep_new;
            idx      <= idx + CW'(1);
         end
      end
   end

`ifdef AXIS_UPSIZE_STATS_EN
   always_ff @(posedge clk) begin
      if (!rstn || stats_clr) begin
         pkt_cnt  <= '0;
         beat_cnt <= '0;
      end else if (hs) begin
         beat_cnt <= beat_cnt + 16'd1;
         if (s_tlast) begin
            pkt_cnt <= pkt_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Testbench for axis_width_upsizer (DW=8, RATIO=4): vector table,
// hand-written corner sequences and a randomized scoreboard run.
module tb_axis_width_upsizer;

   typedef struct {
      logic [7:0]  d;
      logic        l;
      logic        ev;
      logic [31:0] ed;
      logic [3:0]  ek;
      logic        el;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } word_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic        m_tlast;
`ifdef AXIS_UPSIZE_STATS_EN
   logic        stats_clr = 1'b0;
   logic [15:0] pkt_cnt;
   logic [15:0] beat_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int ndrain = 0;
   bit rand_en = 1'b0;
   bit sb_en = 1'b0;
   bit prev_stall = 1'b0;
   word_t prev_word;
   word_t exp_q[$];
   word_t obs_q[$];
   logic [7:0] pkt_q[$];
   vec_t tbl[12];

   axis_width_upsizer #(.DW(8), .RATIO(4)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .s_tlast  (s_tlast),
      .m_tdata  (m_tdata),
      .m_tkeep  (m_tkeep),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast)
`ifdef AXIS_UPSIZE_STATS_EN
      ,
      .stats_clr(stats_clr),
      .pkt_cnt  (pkt_cnt),
      .beat_cnt (beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Samples one time unit before each rising edge, when inputs are settled.
   always @(negedge clk) begin
      #4;
      chk("s_tready_rule", 32'(s_tready),
          32'(rstn && (!m_tvalid || m_tready)));
      if (rstn && prev_stall) begin
         chk("stall_valid", 32'(m_tvalid), 32'd1);
         chk("stall_data", m_tdata, prev_word.d);
         chk("stall_keep", 32'(m_tkeep), 32'(prev_word.k));
         chk("stall_last", 32'(m_tlast), 32'(prev_word.l));
      end
      prev_stall = rstn && m_tvalid && !m_tready;
      prev_word = '{d: m_tdata, k: m_tkeep, l: m_tlast};
      if (rstn && m_tvalid && m_tready) begin
         ndrain++;
         if (sb_en) obs_q.push_back('{d: m_tdata, k: m_tkeep, l: m_tlast});
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send_beat(input logic [7:0] d, input logic l);
      int n = 0;
      s_tdata = d;
      s_tlast = l;
      s_tvalid = 1'b1;
      if (rand_en) m_tready = ($urandom_range(0, 3) != 0);
      #1;
      while (!s_tready && n < 100) begin
         @(negedge clk);
         if (rand_en) m_tready = ($urandom_range(0, 3) != 0);
         #1;
         n++;
      end
      if (!s_tready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=stuck required=accept data=%h", d);
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tdata = 8'($urandom);
      s_tlast = 1'($urandom);
   endtask

   task automatic model_pkt();
      word_t w;
      int n;
      for (int s = 0; s < pkt_q.size(); s += 4) begin
         n = pkt_q.size() - s;
         if (n > 4) n = 4;
         w.d = '0;
         for (int j = 0; j < n; j++) w.d[j*8 +: 8] = pkt_q[s+j];
         w.k = 4'((1 << n) - 1);
         w.l = (s + n == pkt_q.size());
         exp_q.push_back(w);
      end
   endtask

   task automatic chk_out(input string nm, input logic [31:0] d,
                          input logic [3:0] k, input logic l);
      chk({nm, "_valid"}, 32'(m_tvalid), 32'd1);
      chk({nm, "_data"}, m_tdata, d);
      chk({nm, "_keep"}, 32'(m_tkeep), 32'(k));
      chk({nm, "_last"}, 32'(m_tlast), 32'(l));
   endtask

   initial begin
      int nd;
      int len;
      int lim;
      tbl[0]  = '{8'h11, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
      tbl[1]  = '{8'h22, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
      tbl[2]  = '{8'h33, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
      tbl[3]  = '{8'h44, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0};
      tbl[4]  = '{8'h55, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
      tbl[5]  = '{8'h66, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
      tbl[6]  = '{8'h77, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
      tbl[7]  = '{8'h88, 1'b1, 1'b1, 32'h88776655, 4'hF, 1'b1};
      tbl[8]  = '{8'hAA, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
      tbl[9]  = '{8'hBB, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
      tbl[10] = '{8'hCC, 1'b1, 1'b1, 32'h00CCBBAA, 4'h7, 1'b1};
      tbl[11] = '{8'h5A, 1'b1, 1'b1, 32'h0000005A, 4'h1, 1'b1};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_valid", 32'(m_tvalid), 32'd0);
      chk("rst_data", m_tdata, 32'd0);
      chk("rst_keep", 32'(m_tkeep), 32'd0);
      chk("rst_last", 32'(m_tlast), 32'd0);
      rstn = 1'b1;
      m_tready = 1'b1;

      // T1, T2, T4 from the vector table
      for (int i = 0; i < 12; i++) begin
         s_tdata = tbl[i].d;
         s_tlast = tbl[i].l;
         s_tvalid = 1'b1;
         #1;
         chk("tbl_s_tready", 32'(s_tready), 32'd1);
         @(negedge clk);
         s_tvalid = 1'b0;
         chk("tbl_valid", 32'(m_tvalid), 32'(tbl[i].ev));
         if (tbl[i].ev) begin
            chk("tbl_data", m_tdata, tbl[i].ed);
            chk("tbl_keep", 32'(m_tkeep), 32'(tbl[i].ek));
            chk("tbl_last", 32'(m_tlast), 32'(tbl[i].el));
         end
      end

      // T3 backpressure, then drain and new load on the same edge
      send_beat(8'h01, 1'b0);
      send_beat(8'h02, 1'b0);
      send_beat(8'h03, 1'b0);
      send_beat(8'h04, 1'b0);
      chk_out("bp_w1", 32'h04030201, 4'hF, 1'b0);
      m_tready = 1'b0;
      s_tdata = 8'h05;
      s_tlast = 1'b1;
      s_tvalid = 1'b1;
      repeat (3) begin
         #1;
         chk("bp_s_tready", 32'(s_tready), 32'd0);
         @(negedge clk);
         chk_out("bp_hold", 32'h04030201, 4'hF, 1'b0);
      end
      nd = ndrain;
      m_tready = 1'b1;
      #1;
      chk("bp_release", 32'(s_tready), 32'd1);
      @(negedge clk);
      s_tvalid = 1'b0;
      chk_out("bp_w2", 32'h00000005, 4'h1, 1'b1);
      chk("bp_drain1", ndrain, nd + 1);
      @(negedge clk);
      chk("bp_idle", 32'(m_tvalid), 32'd0);
      chk("bp_drain2", ndrain, nd + 2);

      // T5 reset in the middle of a word
      send_beat(8'h01, 1'b0);
      send_beat(8'h02, 1'b0);
      rstn = 1'b0;
      @(negedge clk);
      chk("mr_s_tready", 32'(s_tready), 32'd0);
      chk("mr_valid", 32'(m_tvalid), 32'd0);
      chk("mr_data", m_tdata, 32'd0);
      chk("mr_keep", 32'(m_tkeep), 32'd0);
      rstn = 1'b1;
      send_beat(8'h03, 1'b0);
      send_beat(8'h04, 1'b0);
      send_beat(8'h05, 1'b0);
      chk("mr_nobeat", 32'(m_tvalid), 32'd0);
      send_beat(8'h06, 1'b1);
      chk_out("mr_word", 32'h06050403, 4'hF, 1'b1);

`ifdef AXIS_UPSIZE_STATS_EN
      // T6 counters
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      for (int p = 0; p < 3; p++) begin
         lim = (p == 2) ? 2 : 4;
         for (int j = 0; j < lim; j++) send_beat(8'(j + 1), j == lim - 1);
      end
      chk("st_pkt", 32'(pkt_cnt), 32'd3);
      chk("st_beat", 32'(beat_cnt), 32'd10);
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      chk("st_clr_pkt", 32'(pkt_cnt), 32'd0);
      chk("st_clr_beat", 32'(beat_cnt), 32'd0);
`endif

      // randomized packets against the packet-level model
      repeat (3) @(negedge clk);
      rand_en = 1'b1;
      sb_en = 1'b1;
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 11);
         pkt_q.delete();
         for (int j = 0; j < len; j++) pkt_q.push_back(8'($urandom));
         model_pkt();
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 4) == 0) begin
               m_tready = ($urandom_range(0, 3) != 0);
               @(negedge clk);
            end
            send_beat(pkt_q[j], j == len - 1);
         end
      end
      rand_en = 1'b0;
      m_tready = 1'b1;
      repeat (5) @(negedge clk);
      sb_en = 1'b0;
      chk("sb_count", obs_q.size(), exp_q.size());
      lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < lim; i++) begin
         chk("sb_data", obs_q[i].d, exp_q[i].d);
         chk("sb_keep", 32'(obs_q[i].k), 32'(exp_q[i].k));
         chk("sb_last", 32'(obs_q[i].l), 32'(exp_q[i].l));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
